sopc_run_ctrl: RTL and testbench

Run-control block inside the SOPC: the hardware end of the bench's clock/reset/finish protocol. It conditions the external reset into a clean, stretched CPU reset and counts run cycles. It watches the instruction-fetch PC for a terminal self-loop and reports completion (halt or cycle timeout), freezing the CPU, so benches and FPGA builds get a deterministic end-of-run indication.

---
 rtl/sopc_run_ctrl.sv | 129 ++++++++++++
 tb/tb_sopc_run_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sopc_run_ctrl.sv
`timescale 1ns/1ps
// sopc_run_ctrl
//   Run-control block: turns the external reset into a clean CPU reset that is
//   synchronized and stretched. It counts run cycles and watches the fetch PC
//   for a terminal self-loop. Completion is reported as either halt or timeout,
//   and once the run is done the CPU is held in reset.
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   pc_i       CPU fetch address (valid when ce_i=1)
//   ce_i       CPU fetch enable
//   cpu_rst_o  active-high CPU/memory reset (HOLD and DONE)
//   cycle_o    run cycles elapsed, saturates at MAX_CYCLES
//   done_o     run finished (sticky until reset)
//   halt_o     finished by self-loop detection
//   timeout_o  finished by cycle limit
//   last_pc_o  last fetched PC while running
module sopc_run_ctrl #(
    parameter int MAX_CYCLES  = 800,
    parameter int CNT_W       = 23,
    parameter int RST_STRETCH = 4,
    parameter int HALT_REPEAT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_i,
    input  logic             ce_i,
    output logic             cpu_rst_o,
    output logic [CNT_W-1:0] cycle_o,
    output logic             done_o,
    output logic             halt_o,
    output logic             timeout_o,
    output logic [31:0]      last_pc_o
);

    localparam int SW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
    localparam int MW = $clog2(HALT_REPEAT + 1);

    // The cycle counter must be able to represent the limit.
    if (MAX_CYCLES < 1 || longint'(MAX_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cnt
        $error("sopc_run_ctrl: CNT_W too narrow for MAX_CYCLES");
    end
    if (RST_STRETCH < 1 || HALT_REPEAT < 1) begin : g_bad_par
        $error("sopc_run_ctrl: RST_STRETCH and HALT_REPEAT must be >= 1");
    end

    typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic            sync1, sync2;
    logic [SW-1:0]   stretch;
    logic [1:0]      hist;        // fetches recorded, saturates at 2
    logic [31:0]     pc_d1, pc_d2;
    logic [MW-1:0]   match;
    logic            fetch_match, halt_hit, tmo_hit, stretch_done;

    // pc_d2 is the reference, so a period-2 loop (jump plus delay slot) and a
    // period-1 loop both match on every fetch once the history is full.
    assign fetch_match  = (hist == 2'd2) && (pc_i == pc_d2);
    assign halt_hit     = ce_i && fetch_match && (match == MW'(HALT_REPEAT - 1));
    assign tmo_hit      = (cycle_o == CNT_W'(MAX_CYCLES - 1));
    assign stretch_done = sync2 && (stretch == SW'(RST_STRETCH - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HOLD;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            HOLD:    if (stretch_done) state_nxt = RUN;
            RUN:     if (halt_hit || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = HOLD;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        cpu_rst_o = 1'b1;
        done_o    = 1'b0;
        if (state == RUN)  cpu_rst_o = 1'b0;
        if (state == DONE) done_o    = 1'b1;
    end

    // Datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            stretch   <= '0;
            cycle_o   <= '0;
            hist      <= '0;
            pc_d1     <= '0;
            pc_d2     <= '0;
            match     <= '0;
            last_pc_o <= '0;
            halt_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    sync1 <= 1'b1;
                    sync2 <= sync1;
                    if (sync2 && !stretch_done) stretch <= stretch + SW'(1);
                end
                RUN: begin
                    // Increment on the finishing edge too, so the limit itself
                    // is the value left frozen in DONE.
                    cycle_o   <= cycle_o + CNT_W'(1);
                    halt_o    <= halt_hit;
                    timeout_o <= tmo_hit && !halt_hit;
                    if (ce_i) begin
                        pc_d1     <= pc_i;
                        pc_d2     <= pc_d1;
                        last_pc_o <= pc_i;
                        if (hist != 2'd2) hist <= hist + 2'd1;
                        match <= fetch_match ? match + MW'(1) : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
`timescale 1ns/1ps
// Bench for sopc_run_ctrl. Two instances share the inputs: A uses the defaults
// and B uses MAX_CYCLES=20, which exercises the halt/timeout tie.
module tb_sopc_run_ctrl;
    localparam int RS = 4;
    localparam int HR = 8;
    localparam int MAXA = 800;
    localparam int MAXB = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_i = '0;
    logic        ce_i = 1'b0;

    logic        a_rst, a_done, a_halt, a_tmo, b_rst, b_done, b_halt, b_tmo;
    logic [22:0] a_cycle, b_cycle;
    logic [31:0] a_lpc, b_lpc;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    sopc_run_ctrl u_a (
        .clk(clk), .reset(reset), .pc_i(pc_i), .ce_i(ce_i),
        .cpu_rst_o(a_rst), .cycle_o(a_cycle), .done_o(a_done),
        .halt_o(a_halt), .timeout_o(a_tmo), .last_pc_o(a_lpc)
    );

    sopc_run_ctrl #(.MAX_CYCLES(MAXB)) u_b (
        .clk(clk), .reset(reset), .pc_i(pc_i), .ce_i(ce_i),
        .cpu_rst_o(b_rst), .cycle_o(b_cycle), .done_o(b_done),
        .halt_o(b_halt), .timeout_o(b_tmo), .last_pc_o(b_lpc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. Phases: 0 = held in reset, 1 = running, 2 = finished.
    int          rel = 0;               // rising edges seen since reset released
    logic [31:0] fetched[$];            // every enabled fetch in this run
    int          phase[2]  = '{0, 0};
    int          cyc[2]    = '{0, 0};
    int          streak[2] = '{0, 0};
    logic [31:0] lpc[2]    = '{0, 0};
    bit          hf[2]     = '{0, 0};
    bit          tf[2]     = '{0, 0};
    int          maxc[2]   = '{MAXA, MAXB};

    always @(posedge clk or negedge reset) begin
        bit hit, any_run, h, t;
        if (!reset) begin
            rel = 0;
            fetched.delete();
            for (int m = 0; m < 2; m++) begin
                phase[m] = 0; cyc[m] = 0; streak[m] = 0; lpc[m] = '0; hf[m] = 0; tf[m] = 0;
            end
        end else begin
            hit = ce_i && fetched.size() >= 2 && pc_i == fetched[fetched.size()-2];
            any_run = (phase[0] == 1) || (phase[1] == 1);
            if (rel < 1000) rel++;
            for (int m = 0; m < 2; m++) begin
                if (phase[m] == 0) begin
                    if (rel == 2 + RS) phase[m] = 1;
                end else if (phase[m] == 1) begin
                    cyc[m]++;
                    if (ce_i) begin
                        lpc[m] = pc_i;
                        streak[m] = hit ? streak[m] + 1 : 0;
                    end
                    h = ce_i && streak[m] == HR;
                    t = cyc[m] == maxc[m];
                    if (h || t) begin
                        phase[m] = 2;
                        hf[m] = h;
                        tf[m] = t && !h;
                    end
                end
            end
            if (ce_i && any_run) fetched.push_back(pc_i);
        end
    end

    // Every falling edge, all outputs of both instances are compared with the model.
    always @(negedge clk) begin
        chk("a_cpu_rst", {31'd0, a_rst},  {31'd0, phase[0] != 1});
        chk("a_cycle",   {9'd0, a_cycle}, cyc[0]);
        chk("a_done",    {31'd0, a_done}, {31'd0, phase[0] == 2});
        chk("a_halt",    {31'd0, a_halt}, {31'd0, hf[0]});
        chk("a_timeout", {31'd0, a_tmo},  {31'd0, tf[0]});
        chk("a_last_pc", a_lpc,           lpc[0]);
        chk("b_cpu_rst", {31'd0, b_rst},  {31'd0, phase[1] != 1});
        chk("b_cycle",   {9'd0, b_cycle}, cyc[1]);
        chk("b_done",    {31'd0, b_done}, {31'd0, phase[1] == 2});
        chk("b_halt",    {31'd0, b_halt}, {31'd0, hf[1]});
        chk("b_timeout", {31'd0, b_tmo},  {31'd0, tf[1]});
        chk("b_last_pc", b_lpc,           lpc[1]);
    end

    task automatic drive(input logic [31:0] pc, input logic ce);
        @(negedge clk);
        pc_i = pc;
        ce_i = ce;
    endtask

    // Counts rising edges until cpu_rst_o drops; a missing release is a failure.
    task automatic wait_run(output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            n++;
            if (!a_rst) break;
        end
        if (a_rst) begin
            errors++; checks++;
            $display("FAIL wait_run cpu_rst_o still 1 after %0d edges", n);
        end
    endtask

    task automatic do_reset();
        int n;
        @(negedge clk); #3;
        reset = 1'b0; ce_i = 1'b0; pc_i = '0;
        #40 reset = 1'b1;
        wait_run(n);
    endtask

    // Scripted loop: 0x00,0x04,0x08,0x0C then 0x10,0x14 repeating.
    function automatic logic [31:0] loop_pc(input int k);
        if (k < 4) return 32'(k * 4);
        return (k % 2 == 0) ? 32'h10 : 32'h14;
    endfunction

    initial begin
        int n, k, plen, per;
        logic [31:0] base;

        // Reset held 195 ns, then released.
        #195 reset = 1'b1;
        wait_run(n);
        chk("lit_release_edge", n, 6);
        chk("lit_cycle_start", {9'd0, a_cycle}, 0);
        chk("lit_done_start", {31'd0, a_done}, 0);

        // Fetch loop with ce_i=1 on every cycle: 14th fetch = 8th match.
        for (int i = 0; i < 40; i++) begin
            drive(loop_pc(i), 1'b1);
            @(posedge clk); #1;
            if (a_done) break;
        end
        chk("lit_halt", {31'd0, a_halt}, 1);
        chk("lit_halt_tmo", {31'd0, a_tmo}, 0);
        chk("lit_halt_lpc", a_lpc, 32'h14);
        chk("lit_halt_cycle", {9'd0, a_cycle}, 14);
        chk("lit_halt_rst", {31'd0, a_rst}, 1);

        // Linear PCs: A times out at 800, B at 20.
        do_reset();
        for (int i = 0; i < 900; i++) begin
            drive(32'(i * 4), 1'b1);
            @(posedge clk); #1;
            if (a_done) break;
        end
        chk("lit_tmo", {31'd0, a_tmo}, 1);
        chk("lit_tmo_cycle", {9'd0, a_cycle}, 800);
        chk("lit_tmo_halt", {31'd0, a_halt}, 0);
        chk("lit_b_tmo_cycle", {9'd0, b_cycle}, 20);

        // ce_i toggled: idle cycles carry junk PCs and must be ignored.
        do_reset();
        k = 0;
        for (int i = 0; i < 80; i++) begin
            if (i % 2 == 0) begin drive(loop_pc(k), 1'b1); k++; end
            else drive($urandom, 1'b0);
            @(posedge clk); #1;
            if (a_done) break;
        end
        chk("lit_toggle_halt", {31'd0, a_halt}, 1);
        chk("lit_toggle_cycle", {9'd0, a_cycle}, 27);
        chk("lit_toggle_b_tmo", {31'd0, b_tmo}, 1);

        // Halt and timeout on the same edge for B (6 idle cycles, then 14 fetches).
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (i < 6) drive($urandom, 1'b0);
            else drive(loop_pc(i - 6), 1'b1);
            @(posedge clk); #1;
            if (b_done) break;
        end
        chk("lit_tie_halt", {31'd0, b_halt}, 1);
        chk("lit_tie_tmo", {31'd0, b_tmo}, 0);
        chk("lit_tie_cycle", {9'd0, b_cycle}, 20);

        // 1 ns reset pulse during RUN at cycle 300.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(32'(i * 4), 1'b1);
            @(posedge clk); #1;
            if (a_cycle == 300) break;
        end
        chk("lit_mid_cycle300", {9'd0, a_cycle}, 300);
        #2 reset = 1'b0;
        #1;
        chk("lit_mid_rst", {31'd0, a_rst}, 1);
        chk("lit_mid_cycle", {9'd0, a_cycle}, 0);
        chk("lit_mid_done", {31'd0, b_done}, 0);
        chk("lit_mid_lpc", a_lpc, 0);
        reset = 1'b1;
        wait_run(n);
        chk("lit_restart_edge", n, 6);
        for (int i = 0; i < 3; i++) begin
            drive(32'h100 + 32'(i * 4), 1'b1);
            @(posedge clk); #1;
        end
        chk("lit_restart_cycle", {9'd0, a_cycle}, 3);

        // Randomized runs: random prefix, then a period 1 or 2 loop with random ce.
        for (int it = 0; it < 12; it++) begin
            do_reset();
            plen = $urandom_range(0, 10);
            per  = $urandom_range(1, 2);
            base = {$urandom_range(0, 255), 2'b00};
            for (int i = 0; i < 300; i++) begin
                if (i < plen) drive({$urandom_range(0, 63), 2'b00}, 1'($urandom_range(0, 1)));
                else if ($urandom_range(0, 3) == 0) drive($urandom, 1'b0);
                else drive(base + 32'(((i % per) * 4)), 1'b1);
                @(posedge clk); #1;
                if (a_done) break;
            end
            chk("rand_done", {31'd0, a_done}, 1);
        end

        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
